// File: rtl/timer_ctrl_master_if.sv
// Avalon-MM initiator bus between timer_ctrl_master and the interval timer slave,
// plus the timer's level interrupt.
interface timer_ctrl_master_if;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        timer_irq;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata, timer_irq
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata, timer_irq
  );
endinterface

// File: rtl/timer_ctrl_master.sv
// Programs the interval timer, services its irq by clearing status and counting
// events, and handles on-demand snapshot readback and stop.
module timer_ctrl_master #(
  parameter int READ_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [31:0]          period,
  input  logic                 continuous,
  input  logic                 stop_req,
  input  logic                 snap_req,
  timer_ctrl_master_if.master  avm,
  output logic                 busy,
  output logic [CNT_W-1:0]     event_count,
  output logic                 event_pulse,
  output logic [31:0]          snap_value,
  output logic                 snap_valid
);

  if (READ_LATENCY != 1) begin : g_read_latency_check
    $error("timer_ctrl_master supports READ_LATENCY = 1 only");
  end

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST,
    SNAP_WR, SNAP_RD_L, SNAP_RD_H, SNAP_CAP, STOP_WR
  } state_t;

  typedef struct packed {
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [15:0] wdata;
  } bus_t;

  localparam bus_t BUS_IDLE = '{cs: 1'b0, wn: 1'b1, addr: 3'd0, wdata: 16'h0000};

  // Bus cycle presented while the FSM sits in state st; registered one edge early.
  function automatic bus_t bus_f(input state_t st, input logic [31:0] per, input logic cont);
    bus_t b;
    b = BUS_IDLE;
    case (st)
      WR_PL:     b = '{cs: 1'b1, wn: 1'b0, addr: 3'd2, wdata: per[15:0]};
      WR_PH:     b = '{cs: 1'b1, wn: 1'b0, addr: 3'd3, wdata: per[31:16]};
      WR_CTRL:   b = '{cs: 1'b1, wn: 1'b0, addr: 3'd1, wdata: {12'h000, 1'b0, 1'b1, cont, 1'b1}};
      CLR_ST:    b = '{cs: 1'b1, wn: 1'b0, addr: 3'd0, wdata: 16'h0000};
      SNAP_WR:   b = '{cs: 1'b1, wn: 1'b0, addr: 3'd4, wdata: 16'h0000};
      SNAP_RD_L: b = '{cs: 1'b1, wn: 1'b1, addr: 3'd4, wdata: 16'h0000};
      SNAP_RD_H: b = '{cs: 1'b1, wn: 1'b1, addr: 3'd5, wdata: 16'h0000};
      STOP_WR:   b = '{cs: 1'b1, wn: 1'b0, addr: 3'd1, wdata: 16'h0008};
      default:   b = BUS_IDLE;
    endcase
    return b;
  endfunction

  state_t           state_r;
  state_t           next_s;
  bus_t             bus_r;
  logic [31:0]      period_r;
  logic             cont_r;
  logic             stop_pend_r;
  logic             snap_pend_r;
  logic [15:0]      shadow_lo_r;
  logic [31:0]      period_s;
  logic             cont_s;
  logic             busy_r;
  logic [CNT_W-1:0] count_r;
  logic             event_pulse_r;
  logic [31:0]      snap_value_r;
  logic             snap_valid_r;

  // In IDLE the program words come straight from the inputs being latched this edge.
  always_comb begin
    if (state_r == IDLE) begin
      period_s = period;
      cont_s   = continuous;
    end else begin
      period_s = period_r;
      cont_s   = cont_r;
    end
  end

  // Next-state decode; in RUN the irq outranks stop, which outranks snapshot.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE:      if (start) next_s = WR_PL; else next_s = IDLE;
      WR_PL:     next_s = WR_PH;
      WR_PH:     next_s = WR_CTRL;
      WR_CTRL:   next_s = RUN;
      RUN: begin
        if (avm.timer_irq)    next_s = CLR_ST;
        else if (stop_pend_r) next_s = STOP_WR;
        else if (snap_pend_r) next_s = SNAP_WR;
        else                  next_s = RUN;
      end
      CLR_ST:    if (cont_r) next_s = RUN; else next_s = IDLE;
      SNAP_WR:   next_s = SNAP_RD_L;
      SNAP_RD_L: next_s = SNAP_RD_H;
      SNAP_RD_H: next_s = SNAP_CAP;
      SNAP_CAP:  next_s = RUN;
      STOP_WR:   next_s = IDLE;
      default:   next_s = IDLE;
    endcase
  end

  // State, registered bus cycle, pending flags, counters and snapshot capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      bus_r         <= BUS_IDLE;
      period_r      <= 32'h0000_0000;
      cont_r        <= 1'b0;
      stop_pend_r   <= 1'b0;
      snap_pend_r   <= 1'b0;
      shadow_lo_r   <= 16'h0000;
      busy_r        <= 1'b0;
      count_r       <= '0;
      event_pulse_r <= 1'b0;
      snap_value_r  <= 32'h0000_0000;
      snap_valid_r  <= 1'b0;
    end else begin
      state_r       <= next_s;
      bus_r         <= bus_f(next_s, period_s, cont_s);
      busy_r        <= (next_s != IDLE);
      event_pulse_r <= (next_s == CLR_ST);
      snap_valid_r  <= (state_r == SNAP_CAP);

      if (state_r == IDLE && start) begin
        period_r <= period;
        cont_r   <= continuous;
        count_r  <= '0;
      end else if (next_s == CLR_ST) begin
        count_r <= count_r + CNT_W'(1);
      end

      // Any return to IDLE drops outstanding requests; requests in IDLE are ignored.
      if (state_r == IDLE || next_s == IDLE || next_s == STOP_WR) stop_pend_r <= 1'b0;
      else if (stop_req)                                            stop_pend_r <= 1'b1;

      if (state_r == IDLE || next_s == IDLE || next_s == SNAP_WR) snap_pend_r <= 1'b0;
      else if (snap_req)                                            snap_pend_r <= 1'b1;

      if (state_r == SNAP_RD_H) shadow_lo_r  <= avm.avm_readdata;
      if (state_r == SNAP_CAP)  snap_value_r <= {avm.avm_readdata, shadow_lo_r};
    end
  end

  assign avm.avm_address    = bus_r.addr;
  assign avm.avm_chipselect = bus_r.cs;
  assign avm.avm_write_n    = bus_r.wn;
  assign avm.avm_writedata  = bus_r.wdata;
  assign busy               = busy_r;
  assign event_count        = count_r;
  assign event_pulse        = event_pulse_r;
  assign snap_value         = snap_value_r;
  assign snap_valid         = snap_valid_r;

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Directed bench for timer_ctrl_master with a small timer slave model.
module tb_timer_ctrl_master;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, continuous, stop_req, snap_req;
  logic [31:0] period;
  logic        busy, event_pulse, snap_valid;
  logic [15:0] event_count;
  logic [31:0] snap_value;
  logic [15:0] rdata = 16'h0000;
  int          raise_cnt = 0;
  int          clr_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  timer_ctrl_master_if bus ();
  assign bus.avm_readdata = rdata;
  assign bus.timer_irq    = (raise_cnt != clr_cnt);

  timer_ctrl_master #(.READ_LATENCY(1), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .period(period),
    .continuous(continuous), .stop_req(stop_req), .snap_req(snap_req),
    .avm(bus), .busy(busy), .event_count(event_count), .event_pulse(event_pulse),
    .snap_value(snap_value), .snap_valid(snap_valid)
  );

  always #5 clk = ~clk;

  // Timer slave: irq held until a status write, registered snapshot reads.
  always @(posedge clk) begin
    if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 3'd0)
      clr_cnt <= clr_cnt + 1;
    if (bus.avm_chipselect && bus.avm_write_n)
      rdata <= (bus.avm_address == 3'd4) ? 16'h1234 :
               (bus.avm_address == 3'd5) ? 16'h0005 : 16'h0000;
    else
      rdata <= 16'h0000;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic cs, input logic wn,
                           input logic [2:0] addr, input logic [15:0] wd);
    check(tag, {11'd0, bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata},
               {11'd0, cs, wn, addr, wd});
  endtask

  initial begin
    start = 1'b0; continuous = 1'b0; stop_req = 1'b0; snap_req = 1'b0;
    period = 32'h0; reset_n = 1'b0;
    tick; tick;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check_bus("rst_bus", 1'b0, 1'b1, 3'd0, 16'h0000);
    check("rst_count", {16'd0, event_count}, 32'd0);
    check("rst_snap", snap_value, 32'd0);
    check("rst_snap_valid", {31'd0, snap_valid}, 32'd0);
    check("rst_event_pulse", {31'd0, event_pulse}, 32'd0);
    reset_n = 1'b1;
    tick;

    // Continuous programming sequence
    period = 32'h0000_C350; continuous = 1'b1; start = 1'b1;
    tick; start = 1'b0;
    check("prog_busy", {31'd0, busy}, 32'd1);
    check_bus("prog_pl", 1'b1, 1'b0, 3'd2, 16'hC350);
    tick; check_bus("prog_ph", 1'b1, 1'b0, 3'd3, 16'h0000);
    tick; check_bus("prog_ctrl", 1'b1, 1'b0, 3'd1, 16'h0007);
    tick; check_bus("prog_run_idle", 1'b0, 1'b1, 3'd0, 16'h0000);

    // Three timeouts in RUN
    for (int i = 0; i < 3; i++) begin
      raise_cnt++;
      tick;
      check_bus("irq_clr", 1'b1, 1'b0, 3'd0, 16'h0000);
      check("irq_pulse", {31'd0, event_pulse}, 32'd1);
      check("irq_count", {16'd0, event_count}, i + 1);
      tick;
      check("irq_pulse_low", {31'd0, event_pulse}, 32'd0);
      check_bus("irq_back_run", 1'b0, 1'b1, 3'd0, 16'h0000);
    end
    check("irq_busy", {31'd0, busy}, 32'd1);

    // Snapshot
    snap_req = 1'b1; tick; snap_req = 1'b0;
    check_bus("snap_pend", 1'b0, 1'b1, 3'd0, 16'h0000);
    tick; check_bus("snap_wr", 1'b1, 1'b0, 3'd4, 16'h0000);
    tick; check_bus("snap_rd_l", 1'b1, 1'b1, 3'd4, 16'h0000);
    tick; check_bus("snap_rd_h", 1'b1, 1'b1, 3'd5, 16'h0000);
    tick; check_bus("snap_cap", 1'b0, 1'b1, 3'd0, 16'h0000);
    check("snap_valid_early", {31'd0, snap_valid}, 32'd0);
    tick;
    check("snap_valid", {31'd0, snap_valid}, 32'd1);
    check("snap_value", snap_value, 32'h0005_1234);
    tick; check("snap_valid_drop", {31'd0, snap_valid}, 32'd0);

    // Snapshot with stop pending and irq rising mid-sequence
    snap_req = 1'b1; tick; snap_req = 1'b0;
    tick; check_bus("mix_snap_wr", 1'b1, 1'b0, 3'd4, 16'h0000);
    stop_req = 1'b1; tick; stop_req = 1'b0;
    check_bus("mix_rd_l", 1'b1, 1'b1, 3'd4, 16'h0000);
    raise_cnt++;
    tick; check_bus("mix_rd_h", 1'b1, 1'b1, 3'd5, 16'h0000);
    tick; check_bus("mix_cap", 1'b0, 1'b1, 3'd0, 16'h0000);
    tick; check("mix_snap_valid", {31'd0, snap_valid}, 32'd1);
    tick;
    check_bus("mix_clr", 1'b1, 1'b0, 3'd0, 16'h0000);
    check("mix_count", {16'd0, event_count}, 32'd4);
    check("mix_pulse", {31'd0, event_pulse}, 32'd1);
    tick; check_bus("mix_run", 1'b0, 1'b1, 3'd0, 16'h0000);
    tick; check_bus("mix_stop", 1'b1, 1'b0, 3'd1, 16'h0008);
    tick;
    check("mix_idle_busy", {31'd0, busy}, 32'd0);
    check_bus("mix_idle_bus", 1'b0, 1'b1, 3'd0, 16'h0000);

    // One-shot
    period = 32'h0000_0010; continuous = 1'b0; start = 1'b1;
    tick; start = 1'b0;
    check_bus("os_pl", 1'b1, 1'b0, 3'd2, 16'h0010);
    tick; check_bus("os_ph", 1'b1, 1'b0, 3'd3, 16'h0000);
    tick; check_bus("os_ctrl", 1'b1, 1'b0, 3'd1, 16'h0005);
    tick; check("os_count_cleared", {16'd0, event_count}, 32'd0);
    raise_cnt++;
    tick;
    check_bus("os_clr", 1'b1, 1'b0, 3'd0, 16'h0000);
    check("os_count", {16'd0, event_count}, 32'd1);
    tick;
    check("os_busy", {31'd0, busy}, 32'd0);
    check_bus("os_idle", 1'b0, 1'b1, 3'd0, 16'h0000);

    // Reset during WR_PH
    period = 32'hABCD_1234; continuous = 1'b1; start = 1'b1;
    tick; start = 1'b0;
    check_bus("ar_pl", 1'b1, 1'b0, 3'd2, 16'h1234);
    tick; check_bus("ar_ph", 1'b1, 1'b0, 3'd3, 16'hABCD);
    #2 reset_n = 1'b0;
    #1;
    check_bus("ar_bus", 1'b0, 1'b1, 3'd0, 16'h0000);
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_count", {16'd0, event_count}, 32'd0);
    check("ar_snap", snap_value, 32'd0);
    tick; check_bus("ar_hold", 1'b0, 1'b1, 3'd0, 16'h0000);
    #2 reset_n = 1'b1;
    tick; check_bus("ar_quiet1", 1'b0, 1'b1, 3'd0, 16'h0000);
    check("ar_quiet_busy", {31'd0, busy}, 32'd0);
    tick; check_bus("ar_quiet2", 1'b0, 1'b1, 3'd0, 16'h0000);
    start = 1'b1; tick; start = 1'b0;
    check_bus("re_pl", 1'b1, 1'b0, 3'd2, 16'h1234);
    tick; check_bus("re_ph", 1'b1, 1'b0, 3'd3, 16'hABCD);
    tick; check_bus("re_ctrl", 1'b1, 1'b0, 3'd1, 16'h0007);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
